// File: rtl/opb_status_regbank.sv
// opb_status_regbank: C_NUM_CH 32-bit user status words exposed as OPB slave
// registers. Each channel is built either live (follows user_data_in every
// cycle unless frozen) or sticky (OR-accumulates, write-1-to-clear).
// Optional feature macro: OPB_STATUS_IRQ_EN adds the MASK register and irq.
//
// Register map (word offsets from C_BASEADDR):
//   0 .. C_NUM_CH-1 : channel status words
//   C_NUM_CH        : CTRL, bit0 = freeze (written only when byte lane 3 is enabled)
//   C_NUM_CH+1      : MASK (irq build only, otherwise reads 0)
//   others in range : read 0, writes ignored, still acknowledged
//
// Handshake: a transfer starts when OPB_select is sampled high with an address
// inside [C_BASEADDR, C_HIGHADDR] and no ack is currently being driven.
// Sl_xferAck is high for exactly one cycle on the following cycle; Sl_DBus
// carries read data only in that ack cycle. The master holds select, address
// and data through the ack cycle, so write side effects are applied on the
// clock edge that ends the ack cycle.
module opb_status_regbank #(
    parameter logic [31:0]         C_BASEADDR   = 32'h01020100,
    parameter logic [31:0]         C_HIGHADDR   = 32'h010201FF,
    parameter int                  C_OPB_AWIDTH = 32,
    parameter int                  C_OPB_DWIDTH = 32,
    parameter int                  C_NUM_CH     = 4,
    parameter logic [C_NUM_CH-1:0] C_CH_STICKY  = '0,
    parameter                      C_FAMILY     = "virtex6"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [C_NUM_CH*32-1:0]    user_data_in
`ifdef OPB_STATUS_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int FAMILY_LEN = $bits(C_FAMILY);

    // OPB bit 0 is the MSB, so plain assignment into [31:0] vectors yields
    // the user-numbered view (DBus[0] -> bit 31, BE[0] -> lane for bits 31:24).
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] diff;
    logic [29:0] woff;
    logic        bus_hit;
    logic        xfer_start;
    logic        wr_en;
    logic [31:0] byte_mask;
    logic [31:0] clr_bits;
    logic        freeze;
    logic [31:0] rd_word;
    logic [31:0] rd_q;
    logic [C_NUM_CH*32-1:0] stat_all;
    logic        unused_ok;

    assign addr       = OPB_ABus;
    assign wdata      = OPB_DBus;
    assign be         = OPB_BE;
    assign diff       = addr - C_BASEADDR;
    assign woff       = diff[31:2];
    assign bus_hit    = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign xfer_start = OPB_select & bus_hit & ~Sl_xferAck;
    assign wr_en      = OPB_select & bus_hit & Sl_xferAck & ~OPB_RNW;
    assign byte_mask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign clr_bits   = wdata & byte_mask;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign unused_ok  = &{1'b0, OPB_seqAddr, diff[1:0], FAMILY_LEN[0]};

`ifdef OPB_STATUS_IRQ_EN
    logic [C_NUM_CH-1:0] mask_q;
    logic [C_NUM_CH-1:0] mask_bm;
    logic [C_NUM_CH-1:0] sticky_nz;
    assign mask_bm = byte_mask[C_NUM_CH-1:0];
`endif

    for (genvar k = 0; k < C_NUM_CH; k++) begin : g_ch
        logic [31:0] in_word;
        logic [31:0] stat_q;
        assign in_word = user_data_in[32*k +: 32];
        assign stat_all[32*k +: 32] = stat_q;
`ifdef OPB_STATUS_IRQ_EN
        assign sticky_nz[k] = C_CH_STICKY[k] & (|stat_q);
`endif
        if (C_CH_STICKY[k]) begin : g_sticky
            logic [31:0] clr;
            assign clr = (wr_en && (woff == 30'(k))) ? clr_bits : 32'h0;
            // Sticky word: accumulate every cycle; a coincident set beats the clear.
            always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                if (!OPB_Rst_n) begin
                    stat_q <= 32'h0;
                end else begin
                    stat_q <= (stat_q & ~clr) | in_word;
                end
            end
        end else begin : g_live
            // Live word: follow the input unless software froze the bank.
            always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                if (!OPB_Rst_n) begin
                    stat_q <= 32'h0;
                end else if (!freeze) begin
                    stat_q <= in_word;
                end
            end
        end
    end

    // CTRL freeze bit, written on the ack edge when byte lane 3 is enabled.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            freeze <= 1'b0;
        end else if (wr_en && (woff == 30'(C_NUM_CH)) && be[0]) begin
            freeze <= wdata[0];
        end
    end

`ifdef OPB_STATUS_IRQ_EN
    // MASK register: only the byte lanes enabled by the write are updated.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            mask_q <= '0;
        end else if (wr_en && (woff == 30'(C_NUM_CH + 1))) begin
            mask_q <= (mask_q & ~mask_bm) | (wdata[C_NUM_CH-1:0] & mask_bm);
        end
    end

    // Registered interrupt: any enabled sticky channel holding a set bit.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(mask_q & sticky_nz);
        end
    end
`endif

    // Read multiplexer over the word offset; unmapped offsets read zero.
    always_comb begin
        rd_word = 32'h0;
        for (int k = 0; k < C_NUM_CH; k++) begin
            if (woff == 30'(k)) begin
                rd_word = stat_all[32*k +: 32];
            end
        end
        if (woff == 30'(C_NUM_CH)) begin
            rd_word = {31'h0, freeze};
        end
`ifdef OPB_STATUS_IRQ_EN
        if (woff == 30'(C_NUM_CH + 1)) begin
            rd_word = 32'(mask_q);
        end
`endif
    end

    // Ack generation and read-data register; data is nonzero only in a read ack cycle.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            Sl_xferAck <= 1'b0;
            rd_q       <= 32'h0;
        end else begin
            Sl_xferAck <= xfer_start;
            rd_q       <= (xfer_start & OPB_RNW) ? rd_word : 32'h0;
        end
    end

    assign Sl_DBus = rd_q;

endmodule
